// File: rtl/pdt_tournament.sv
// Tournament branch predictor: local + (g)share global components with a chooser.
// Tables are swept to weakly-not-taken after reset before predictions are valid.
module pdt_tournament #(
   parameter int INDEX_BITS = 10,
   parameter int GHR_BITS   = 10,
   parameter int LHR_BITS   = 4,
   parameter int GSHARE     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         if_pc,
   input  logic [31:0]         if_inst,
   output logic                ready,
   output logic                branch_or_not,
   output logic [31:0]         pdt_pc,
   output logic                pdt_res,
   output logic                which_pdt_o,
   output logic [GHR_BITS-1:0] pred_ghr,
   output logic [LHR_BITS-1:0] pred_lhr,
   output logic                pred_local,
   output logic                pred_global,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic                upd_taken,
   input  logic [GHR_BITS-1:0] upd_ghr,
   input  logic [LHR_BITS-1:0] upd_lhr,
   input  logic                upd_local,
   input  logic                upd_global,
   input  logic                upd_mispdt,
   output logic [31:0]         miss_cnt
);

   localparam int NI = 1 << INDEX_BITS;
   localparam int NG = 1 << GHR_BITS;
   localparam int NL = 1 << LHR_BITS;

   typedef enum logic [1:0] {
      S_RESET,
      S_INIT,
      S_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] sweep_q, sweep_d;
   logic [GHR_BITS-1:0]   ghr_q, ghr_d;
   logic [31:0]           miss_q, miss_d;

   logic [1:0]            cho_q  [NI];
   logic [LHR_BITS-1:0]   lht_q  [NI];
   logic [1:0]            lpht_q [NI][NL];
   logic [1:0]            gpht_q [NG];

   logic [INDEX_BITS-1:0] idx;
   logic [GHR_BITS-1:0]   gidx;
   logic [INDEX_BITS-1:0] uidx;
   logic [GHR_BITS-1:0]   ugidx;
   logic [LHR_BITS-1:0]   lhr;
   logic                  upd_en;
   logic                  is_br;
   logic                  is_jal;
   logic [31:0]           bimm;
   logic [31:0]           jimm;
   logic                  unused_upd;

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   assign unused_upd = ^{upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

   assign idx  = if_pc[INDEX_BITS+1:2];
   assign uidx = upd_pc[INDEX_BITS+1:2];
   assign gidx = (GSHARE != 0) ? (ghr_q ^ if_pc[GHR_BITS+1:2]) : ghr_q;
   assign ugidx = (GSHARE != 0) ? (upd_ghr ^ upd_pc[GHR_BITS+1:2]) : upd_ghr;
   assign lhr  = lht_q[idx];

   assign ready  = (state_q == S_RUN);
   assign upd_en = ready & upd_valid;

   assign is_br  = ready & (if_inst[6:0] == 7'b1100011);
   assign is_jal = ready & (if_inst[6:0] == 7'b1101111);

   assign bimm = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                  if_inst[30:25], if_inst[11:8], 1'b0};
   assign jimm = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                  if_inst[20], if_inst[30:21], 1'b0};

   assign which_pdt_o = cho_q[idx][1];
   assign pred_local  = lpht_q[idx][lhr][1];
   assign pred_global = gpht_q[gidx][1];
   assign pred_ghr    = ghr_q;
   assign pred_lhr    = lhr;
   assign miss_cnt    = miss_q;

   // Next-state logic: one-shot RESET, table sweep in INIT, then RUN.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         S_RESET: begin
            state_d = S_INIT;
            sweep_d = '0;
         end
         S_INIT: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = S_RUN;
         end
         S_RUN: ;
         default: state_d = S_RESET;
      endcase
   end

   // Direction/target selection; non-branches fall through to pc+4.
   always_comb begin
      branch_or_not = 1'b0;
      pdt_res       = 1'b0;
      pdt_pc        = if_pc + 32'd4;
      unique case (1'b1)
         is_br: begin
            branch_or_not = 1'b1;
            pdt_res       = which_pdt_o ? pred_global : pred_local;
            if (pdt_res) pdt_pc = if_pc + bimm;
         end
         is_jal: begin
            branch_or_not = 1'b1;
            pdt_res       = 1'b1;
            pdt_pc        = if_pc + jimm;
         end
         default: ;
      endcase
   end

   // Global history and misprediction counter advance on RUN updates.
   always_comb begin
      ghr_d  = ghr_q;
      miss_d = miss_q;
      if (upd_en) begin
         ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken};
         if (upd_mispdt) miss_d = miss_q + 32'd1;
      end
   end

   // FSM, sweep, history and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
         sweep_q <= '0;
         ghr_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         ghr_q   <= ghr_d;
         miss_q  <= miss_d;
      end
   end

   // Table storage: initialised by the sweep, trained by resolved branches.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_INIT) begin
         cho_q[sweep_q] <= 2'b01;
         lht_q[sweep_q] <= '0;
         for (int j = 0; j < NL; j++) begin
            lpht_q[sweep_q][j] <= 2'b01;
         end
         gpht_q[sweep_q[GHR_BITS-1:0]] <= 2'b01;
      end else if (!rst && upd_en) begin
         lpht_q[uidx][upd_lhr] <= sat2(lpht_q[uidx][upd_lhr], upd_taken);
         gpht_q[ugidx] <= sat2(gpht_q[ugidx], upd_taken);
         lht_q[uidx] <= {lht_q[uidx][LHR_BITS-2:0], upd_taken};
         if (upd_local != upd_global) begin
            cho_q[uidx] <= sat2(cho_q[uidx], upd_global == upd_taken);
         end
      end
   end

endmodule
